// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a shared memory port with RMW bus locking.
// Define MEM_ARBITER_WATCHDOG_EN to add the grant watchdog and per-master blocking.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  output logic        m0_gnt,
  output logic        m1_gnt,
  input  logic [63:0] m0_ad,
  input  logic [7:0]  m0_tag,
  input  logic        m0_astb,
  input  logic        m0_atomic,
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic [63:0] m1_ad,
  input  logic [7:0]  m1_tag,
  input  logic        m1_astb,
  input  logic        m1_atomic,
  input  logic        m1_rd,
  input  logic        m1_wr,
  output logic [63:0] o_ad,
  output logic [7:0]  o_tag,
  output logic        o_astb,
  output logic        o_atomic,
  output logic        o_rd,
  output logic        o_wr,
  output logic        o_owner,
  output logic        proto_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e     state_q, state_d;
  logic       lock_q, lock_d;
  logic       rr_q, rr_d;            // 1: master 1 wins the next tie
  logic       proto_err_q, proto_err_d;
  logic       own0, own1, own_req, own_stb, stb0, stb1;
  logic [1:0] elig;
  logic       expire;

  assign own0    = (state_q == GRANT0);
  assign own1    = (state_q == GRANT1);
  assign own_req = own1 ? m1_req : m0_req;
  assign stb0    = m0_astb | m0_rd | m0_wr;
  assign stb1    = m1_astb | m1_rd | m1_wr;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_ad     = '0;
    o_tag    = '0;
    o_astb   = 1'b0;
    o_atomic = 1'b0;
    o_rd     = 1'b0;
    o_wr     = 1'b0;
    if (own0) begin
      o_ad = m0_ad; o_tag = m0_tag; o_astb = m0_astb;
      o_atomic = m0_atomic; o_rd = m0_rd; o_wr = m0_wr;
    end else if (own1) begin
      o_ad = m1_ad; o_tag = m1_tag; o_astb = m1_astb;
      o_atomic = m1_atomic; o_rd = m1_rd; o_wr = m1_wr;
    end
  end

  assign own_stb = o_astb | o_rd | o_wr;

`ifdef MEM_ARBITER_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic [1:0]  blocked_q, blocked_d;
  logic        timeout_err_q;

  // Counter idles at zero, so it is already clear on entry to a grant state.
  always_comb begin
    wd_cnt_d = '0;
    expire   = 1'b0;
    if (state_q != IDLE && !own_stb) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
      expire   = (wd_cnt_d == TIMEOUT_W);
    end
    blocked_d = (blocked_q & {m1_req, m0_req}) | {expire & own1, expire & own0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q      <= '0;
      blocked_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      blocked_q     <= blocked_d;
      timeout_err_q <= expire;
    end
  end

  assign elig        = {m1_req, m0_req} & ~blocked_q;
  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign elig           = {m1_req, m0_req};
  assign expire         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    rr_d        = rr_q;
    proto_err_d = (stb0 & ~own0) | (stb1 & ~own1);
    case (state_q)
      IDLE: begin
        lock_d = 1'b0;
        if (elig[0] && (!elig[1] || !rr_q)) begin
          state_d = GRANT0;
          rr_d    = 1'b1;
        end else if (elig[1]) begin
          state_d = GRANT1;
          rr_d    = 1'b0;
        end
      end
      GRANT0, GRANT1: begin
        if (o_astb && o_atomic) lock_d = 1'b1;
        // A write in the same cycle releases the lock so the bus can go idle at once.
        if (o_wr) lock_d = 1'b0;
        if (expire) begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end else if (!own_req && !lock_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      lock_q      <= 1'b0;
      rr_q        <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      rr_q        <= rr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign m0_gnt    = own0;
  assign m1_gnt    = own1;
  assign o_owner   = own1;
  assign proto_err = proto_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, watchdog limit in clk cycles (1..65535).
REQ-002 Ports (name direction width meaning):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  bus request from master 0 (CPU) or master 1 (I/O channel).
- m0_gnt, m1_gnt  out  1  registered bus grant.
- mN_ad  in  64  address/data from master N.
- mN_tag  in  8  tag from master N.
- mN_astb  in  1  address strobe from master N.
- mN_atomic  in  1  read-modify-write flag from master N.
- mN_rd  in  1  read strobe from master N.
- mN_wr  in  1  write strobe from master N.
- o_ad  out  64  address/data to tmemory.
- o_tag  out  8  tag to tmemory.
- o_astb  out  1  address strobe to tmemory.
- o_atomic  out  1  read-modify-write flag to tmemory.
- o_rd  out  1  read strobe to tmemory.
- o_wr  out  1  write strobe to tmemory.
- o_owner  out  1  index of the current grantee; valid while any gnt is high.
- proto_err  out  1  one-cycle pulse: non-granted master asserted a strobe.
- timeout_err  out  1  one-cycle pulse: watchdog forced a release.
REQ-003 Read data (i_data, i_tag) is not routed by the block; both masters receive the memory output directly.

Function
REQ-004 FSM states: IDLE, GRANT0, GRANT1.
- m0_gnt = (state == GRANT0).
- m1_gnt = (state == GRANT1).
- o_owner = (state == GRANT1).
REQ-005 IDLE, one eligible request: grant that master next cycle.
REQ-006 IDLE, both eligible: grant the master that did not own the bus last (round-robin); after reset, master 0 wins.
REQ-007 GRANTn to IDLE when mN_req == 0 and lock == 0; there is no direct GRANT0 to GRANT1 transition (minimum one quiet IDLE cycle between owners).
REQ-008 Bus mux is combinational from the owner while in GRANTn; all o_* outputs are 0 in IDLE.
REQ-009 Lock flag:
- set on a cycle where the owner asserts astb and atomic together;
- cleared on a cycle where the owner asserts wr;
- while set, the grant is held regardless of req.
REQ-010 Owner strobes after it drops req (grant not yet released) still pass to memory.
REQ-011 proto_err pulses the cycle after any non-owner asserts astb, rd or wr; those strobes are never forwarded.
REQ-012 Watchdog counter (16 bit):
- cleared on entry to GRANTn and on any owner strobe;
- increments each other GRANTn cycle;
- on reaching TIMEOUT: next state IDLE, lock cleared, timeout_err pulses one cycle.
REQ-013 A timed-out master is blocked (not eligible) until it deasserts req for at least one cycle.
REQ-014 Simultaneous watchdog expiry and owner req drop: the timeout takes precedence (timeout_err pulses, blocked flag set).

Reset
REQ-015 While reset is high, on the next clk edge:
- state = IDLE, so all o_*, gnt and error outputs are 0;
- lock, watchdog counter and blocked flags are cleared;
- round-robin pointer selects master 0.
REQ-016 Reset mid-transaction (including a locked RMW) abandons it; no strobe is emitted in the cycle after reset is asserted.

Configuration
REQ-017 Macro MEM_ARBITER_WATCHDOG_EN:
- defined: REQ-012..REQ-014 are implemented;
- undefined: no counter and no blocked flags, a grant is held indefinitely, and timeout_err is tied to 0.

Verification
REQ-018 Reset, then m0_req=1 at cycle 0: m0_gnt=1 at cycle 1; m0_astb with m0_ad=0x12345 appears as o_astb=1, o_ad=0x12345 in the same cycle.
REQ-019 Both req=1 from IDLE after reset:
- GRANT0;
- m0_req drops: IDLE for one cycle with all o_* = 0, then GRANT1.
REQ-020 Master 1 RMW (astb+atomic, rd, then m1_req=0, wr 3 cycles later): the grant is held until the wr cycle, and m0 (requesting throughout) is granted 2 cycles after wr.
REQ-021 m1_wr=1 while m0 owns the bus: o_wr=0, proto_err=1 for one cycle.
REQ-022 With the macro defined and TIMEOUT=4, m0 holds req with no strobes:
- timeout_err pulses, IDLE follows, and m0 is not re-granted while req stays 1;
- after req 0 then 1, m0 is granted again.
REQ-023 Macro undefined, same stimulus: m0_gnt stays 1 for 1000 cycles and timeout_err stays 0.
